// File: rtl/sub_by_one_counter.sv
// Loadable down-counter with borrow-lookahead decrement and start/busy/done handshake.
// Optional periodic auto-reload mode enabled by defining SUB_BY_ONE_AUTO_RELOAD_EN.
module sub_by_one_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TERM = 2'd2
    } state_t;

    state_t           state_reg, state_next, start_state;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] borrow;
    logic [WIDTH-1:0] dec_val;
`ifdef SUB_BY_ONE_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_reg, reload_next;
`endif

    // Each borrow is a flat AND of all lower bits being zero, so no ripple path.
    assign borrow[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_borrow
            assign borrow[gi] = ~|q_reg[gi-1:0];
        end
    endgenerate
    assign dec_val = q_reg ^ borrow;

    assign Q           = q_reg;
    assign zero        = (q_reg == '0);
    assign start_state = (load_val != '0) ? RUN : TERM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            q_reg      <= '0;
`ifdef SUB_BY_ONE_AUTO_RELOAD_EN
            reload_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            q_reg      <= q_next;
`ifdef SUB_BY_ONE_AUTO_RELOAD_EN
            reload_reg <= reload_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        q_next      = q_reg;
`ifdef SUB_BY_ONE_AUTO_RELOAD_EN
        reload_next = reload_reg;
`endif
        if (load) begin
            // A load restarts the count from any state and beats en.
            q_next     = load_val;
            state_next = start_state;
`ifdef SUB_BY_ONE_AUTO_RELOAD_EN
            reload_next = load_val;
`endif
        end else begin
            case (state_reg)
                IDLE: state_next = IDLE;
                RUN: begin
                    // Zero is never decremented, so the count cannot wrap.
                    if (en && !zero) begin
                        q_next = dec_val;
                        if (q_reg == WIDTH'(1)) state_next = TERM;
                    end
                end
                TERM: begin
`ifdef SUB_BY_ONE_AUTO_RELOAD_EN
                    if (reload_reg != '0) begin
                        q_next     = reload_reg;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        done = (state_reg == TERM);
`ifdef SUB_BY_ONE_AUTO_RELOAD_EN
        busy = (state_reg == RUN) || (state_reg == TERM);
`else
        busy = (state_reg == RUN);
`endif
    end

endmodule

// File: tb/tb_sub_by_one_counter.sv
// Scoreboard bench for sub_by_one_counter: a reference model pushes expected outputs
// per driven cycle, which are popped and compared after the following clock edge.
module tb_sub_by_one_counter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic [W-1:0] Q;
    logic         busy, done, zero;

    always #5 clk = ~clk;

    sub_by_one_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
        .Q(Q), .busy(busy), .done(done), .zero(zero)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        logic         zero;
    } exp_t;

    exp_t         sb[$];
    int           vectors     = 0;
    int           miscompares = 0;
    int           m_state;      // 0 idle, 1 run, 2 term
    logic [W-1:0] m_q, m_reload;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_q      = '0;
        m_reload = '0;
    endtask

    task automatic model_step(input logic ld, input logic [W-1:0] v, input logic e);
        if (ld) begin
            m_q      = v;
            m_reload = v;
            m_state  = (v != 0) ? 1 : 2;
        end else if (m_state == 1) begin
            if (e && m_q != 0) begin
                m_q = m_q - 1'b1;
                if (m_q == 0) m_state = 2;
            end
        end else if (m_state == 2) begin
`ifdef SUB_BY_ONE_AUTO_RELOAD_EN
            if (m_reload != 0) begin
                m_q     = m_reload;
                m_state = 1;
            end else begin
                m_state = 0;
            end
`else
            m_state = 0;
`endif
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.q    = m_q;
`ifdef SUB_BY_ONE_AUTO_RELOAD_EN
        x.busy = (m_state == 1) || (m_state == 2);
`else
        x.busy = (m_state == 1);
`endif
        x.done = (m_state == 2);
        x.zero = (m_q == 0);
        return x;
    endfunction

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic ld, input logic [W-1:0] v, input logic e);
        exp_t x;
        @(negedge clk);
        load     = ld;
        load_val = v;
        en       = e;
        model_step(ld, v, e);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        x = sb.pop_front();
        $display("cycle ld=%0b v=%0h en=%0b -> Q=%0h busy=%0b done=%0b zero=%0b",
                 ld, v, e, Q, busy, done, zero);
        check_val("q", 32'(Q), 32'(x.q));
        check_val("busy", 32'(busy), 32'(x.busy));
        check_val("done", 32'(done), 32'(x.done));
        check_val("zero", 32'(zero), 32'(x.zero));
    endtask

    function automatic logic [W-1:0] borrow_dec(input logic [W-1:0] v);
        logic [W-1:0] b;
        b[0] = 1'b1;
        for (int i = 1; i < W; i++) b[i] = b[i-1] & ~v[i-1];
        return v ^ b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int           cnt;
        int           dones;
        logic [W-1:0] prev;
        logic         seen;

        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_q", 32'(Q), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_done", 32'(done), 32'(0));
        check_val("rst_zero", 32'(zero), 32'(1));
        @(negedge clk);
        rst = 1'b0;

        // Idle with en high must never wrap
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, 1'b1);
            check_val("no_wrap", 32'(Q == 4'hF), 32'(0));
        end

        // Load 5, en held
        step(1'b1, 4'd5, 1'b1);
        for (int k = 0; k < 7; k++) step(1'b0, '0, 1'b1);

        // Load 9, toggling en; done after 9 enabled edges
        step(1'b1, 4'd9, 1'b0);
        cnt = 0; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step(1'b0, '0, (k % 2) == 0);
            if ((k % 2) == 0) cnt++;
            if (done) seen = 1'b1;
        end
        check_val("done_seen_9", 32'(seen), 32'(1));
        check_val("en_edges_9", 32'(cnt), 32'(9));
        step(1'b0, '0, 1'b1);

        // Load 7, reload 2 at Q=4 with en high: load wins
        step(1'b1, 4'd7, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
        check_val("q_before_override", 32'(Q), 32'(4));
        dones = 0;
        step(1'b1, 4'd2, 1'b1);
        check_val("override_q", 32'(Q), 32'(2));
        for (int k = 0; k < 4; k++) begin
            step(1'b0, '0, 1'b1);
            if (done) dones++;
        end
        check_val("override_dones", 32'(dones), 32'(1));

        // Load 0: immediate done, busy never high
        step(1'b1, 4'd0, 1'b1);
        check_val("load0_done", 32'(done), 32'(1));
        step(1'b0, '0, 1'b0);
`ifndef SUB_BY_ONE_AUTO_RELOAD_EN
        check_val("load0_busy", 32'(busy), 32'(0));
`endif

        // Load 15: every step checked against the borrow equation
        step(1'b1, 4'hF, 1'b1);
        for (int k = 0; k < 15; k++) begin
            prev = Q;
            step(1'b0, '0, 1'b1);
            check_val("borrow_eq", 32'(Q), 32'(borrow_dec(prev)));
        end
        step(1'b0, '0, 1'b0);

`ifdef SUB_BY_ONE_AUTO_RELOAD_EN
        // Periodic mode: load 3 gives a done every 4 cycles
        step(1'b1, 4'd3, 1'b1);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, '0, 1'b1);
            if (done) dones++;
        end
        check_val("auto_dones", 32'(dones), 32'(3));
        check_val("auto_q", 32'(Q), 32'(3));
`endif

        // Async reset mid-cycle while Q=3
        step(1'b1, 4'd5, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check_val("q_before_rst", 32'(Q), 32'(3));
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_val("arst_q", 32'(Q), 32'(0));
        check_val("arst_busy", 32'(busy), 32'(0));
        check_val("arst_done", 32'(done), 32'(0));
        check_val("arst_zero", 32'(zero), 32'(1));
        model_reset();
        @(posedge clk);
        #1;
        check_val("arst_hold_done", 32'(done), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sub_by_one_counter.md
Name: sub_by_one_counter

Overview:
- Loadable down-counter: each enabled cycle it subtracts one from a WIDTH-bit value using a borrow-lookahead chain.
- Reports terminal count with a start/busy/done handshake.
- Decrement-side companion to the team's increment adder; used as a countdown timer or loop counter in the datapath controller.

Parameters:
WIDTH, 4, counter width in bits (WIDTH >= 2)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  start strobe; captures load_val
load_val  input  WIDTH  initial count
en  input  1  count enable; decrement occurs only when high in RUN
Q  output  WIDTH  current count (registered)
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on reaching terminal count
zero  output  1  combinational, (Q == 0)

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous and active-high.
- Reset values: Q=0, busy=0, done=0, zero=1, state=IDLE, reload register=0.
- Decrement datapath:
  - b[0]=1; b[i] = ~Q[i-1] & ... & ~Q[0], computed flat, not rippled.
  - D[i] = Q[i] ^ b[i], i.e. D = Q - 1 mod 2^WIDTH.
  - Decrement never adds extra cycles; Q updates the edge after en is sampled high.
- State IDLE:
  - busy=0; Q holds.
  - load=1 and load_val!=0: Q<=load_val, reload<=load_val, next state RUN.
  - load=1 and load_val==0: Q<=0, next state TERM.
  - en is ignored in IDLE; Q never wraps while idle.
- State RUN:
  - busy=1.
  - load=1 has priority over en: Q<=load_val, restart as in IDLE (TERM if load_val==0).
  - Otherwise en=1: Q<=D. If Q==1 on that edge, Q becomes 0 and next state is TERM.
  - en=0: Q holds; state holds.
- State TERM:
  - Lasts exactly one cycle; done=1, busy=0, Q=0.
  - Next state IDLE.
  - load=1 during TERM is accepted as in IDLE. The done pulse is still emitted that cycle.
- Latency:
  - Load of N (N>=1) with en held high: done asserts N cycles after the load edge.
  - Load of 0: done asserts in the cycle right after the load edge.
- Wrap-around: Q==0 is never decremented in any state; the 0 -> 2^WIDTH-1 transition is unreachable. A bench must flag it if it occurs.
- Asynchronous reset mid-count returns every output to its reset value immediately, with no done pulse. The first edge after rst deasserts behaves as IDLE.
- done is registered: it is the state==TERM decode, never combinational from en.

Optional Feature:
- Macro: SUB_BY_ONE_AUTO_RELOAD_EN.
- Defined: TERM moves to RUN instead of IDLE, with Q<=reload. The block runs periodically with period reload+1 cycles when en is held high. The done pulse is emitted once per period, and busy stays high through TERM.
  - A load in TERM overrides the reload value.
  - A reload value of 0 behaves as not defined.
- Not defined: behaviour exactly as above; TERM always returns to IDLE; the reload register may be optimised away.

Test Plan:
- Reset then idle 5 cycles with en=1 -> Q=0, zero=1, busy=0, done=0 throughout; no wrap to 4'hF.
- load=1, load_val=4'd5, en held 1 -> Q: 5,4,3,2,1,0 on successive edges; done high exactly one cycle when Q=0; busy falls with done.
- load 4'd9, then toggle en 1,0,1,0... -> Q decrements only on en=1 edges; done after 9 enabled edges.
- load 4'd7, after Q=4 assert load with 4'd2 and en=1 the same cycle -> Q=2 (load wins), then 1, 0, one done pulse.
- load 4'd0 -> next cycle done=1 with busy never asserted; load 4'hF with en=1 -> 15 decrements; each step checked against the borrow equation.
- Assert rst asynchronously mid-cycle while Q=3 -> Q=0, busy=0, done=0 before the next edge. With SUB_BY_ONE_AUTO_RELOAD_EN defined, load 4'd3 -> done pulses every 4 cycles and Q cycles 3,2,1,0.
